uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_pkg.sv | 15 +
 rtl/uart_tx_fifo_if.sv | 34 +++
 rtl/uart_fifo_mem.sv | 32 +++
 rtl/uart_tx_fifo.sv | 114 +++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO.
// Holds the default word width and depth, and the
// transmit handshake state encoding.
package uart_tx_fifo_pkg;

  localparam int DEF_DATA_LENGTH = 8;
  localparam int DEF_DEPTH       = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bus bundle between the UART transmit FIFO and its surroundings.
//   write side : wr_en, wr_data -> full, empty, count, overflow
//   tx side    : tx_data, tx_start -> transmitter; tx_busy, tx_done <- transmitter
// The slave modport is the FIFO's view of the bus.
// The master modport is the view of the writer and the transmitter.
interface uart_tx_fifo_if
  import uart_tx_fifo_pkg::*;
#(
  parameter int DATA_LENGTH = DEF_DATA_LENGTH,
  parameter int DEPTH       = DEF_DEPTH
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                   wr_en;
  logic [DATA_LENGTH-1:0] wr_data;
  logic                   full;
  logic                   empty;
  logic [CW-1:0]          count;
  logic                   overflow;
  logic [DATA_LENGTH-1:0] tx_data;
  logic                   tx_start;
  logic                   tx_busy;
  logic                   tx_done;

  modport slave (
    input  wr_en, wr_data, tx_busy, tx_done,
    output full, empty, count, overflow, tx_data, tx_start
  );

  modport master (
    output wr_en, wr_data, tx_busy, tx_done,
    input  full, empty, count, overflow, tx_data, tx_start
  );
endinterface

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage for the transmit FIFO.
// Writes are synchronous. Reads are asynchronous, so the head word
// can be captured on the same edge that pops it.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
// The contents are not reset.
module uart_fifo_mem
  import uart_tx_fifo_pkg::*;
#(
  parameter int DATA_LENGTH = DEF_DATA_LENGTH,
  parameter int DEPTH       = DEF_DEPTH,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [DATA_LENGTH-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [DATA_LENGTH-1:0] rdata
);
  logic [DATA_LENGTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit FIFO.
// It buffers words from a writer and hands them one at a time to a
// UART transmitter using a start/busy/done handshake.
//   clk : system clock, shared with the transmitter
//   rst : synchronous active-high reset
//   bus : uart_tx_fifo_if.slave
//         wr_en/wr_data  enqueue
//         full/empty/count/overflow  status
//         tx_data/tx_start  to the transmitter
//         tx_busy/tx_done  from the transmitter
// The interface parameters must match DATA_LENGTH and DEPTH.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DATA_LENGTH = DEF_DATA_LENGTH,
  parameter int DEPTH       = DEF_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  tx_state_e              state_q, state_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   full_q, full_d;
  logic                   empty_q, empty_d;
  logic [DATA_LENGTH-1:0] tx_data_q, tx_data_d;
  logic                   tx_start_q, tx_start_d;
  logic                   overflow_q, overflow_d;

  logic                   push, pop;
  logic [DATA_LENGTH-1:0] rd_data;

  uart_fifo_mem #(
    .DATA_LENGTH(DATA_LENGTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr_q),
    .wdata(bus.wr_data),
    .raddr(rd_ptr_q),
    .rdata(rd_data)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        // Empty is registered, so a word written this cycle cannot be
        // popped until the next cycle (no write-through to the transmitter).
        if (!empty_q && !bus.tx_busy) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND:      state_d = WAIT_DONE;
      WAIT_DONE: if (bus.tx_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    // When the FIFO is full, a pop on the same edge frees a slot,
    // so the write is taken instead of being dropped.
    push       = bus.wr_en && (!full_q || pop);
    overflow_d = bus.wr_en && full_q && !pop;

    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    full_d     = (count_d == CW'(DEPTH));
    empty_d    = (count_d == '0);

    tx_start_d = pop;
    tx_data_d  = pop ? rd_data : tx_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
endmodule
